bcd_stopwatch_ctrl: RTL and testbench
=====================================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 Parameter: PRESCALE, default 1000, clk cycles per count increment (legal range 2..65535).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  single-cycle request to begin/resume counting.
REQ-005 stop  input  1  single-cycle request to pause counting.
REQ-006 clear  input  1  single-cycle request to zero the count and return to idle.
REQ-007 lap  input  1  single-cycle request to toggle display hold.
REQ-008 bcd  output  16  displayed 4-digit packed BCD value; digit0 at [3:0], digit3 at [15:12].
REQ-009 running  output  1  high while in RUN.
REQ-010 held  output  1  high while display hold is active.
REQ-011 ovf  output  1  high while in OVF.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and OVF.
REQ-013 Input priority within one cycle SHALL be clear > stop > start > lap. A lower-priority request in the same cycle SHALL be ignored, except that lap is evaluated alongside start/stop when clear is absent.
REQ-014 In any state, clear SHALL zero the count and the prescaler, drop hold, and go to IDLE on the next edge.
REQ-015 IDLE + start -> RUN; PAUSE + start -> RUN; RUN + stop -> PAUSE. start in RUN and stop in IDLE/PAUSE/OVF are no-ops.
REQ-016 The prescaler SHALL be zeroed on every entry to RUN and SHALL count only in RUN. It is frozen in PAUSE.
REQ-017 When the prescaler equals PRESCALE-1 in RUN, it SHALL wrap to 0 and the count SHALL increment by one on that edge. The first increment occurs PRESCALE cycles after the edge that entered RUN.
REQ-018 Increment arithmetic SHALL be per-digit BCD: a digit at 9 becomes 0 and carries into the next digit. No digit may ever hold A-F.
REQ-019 An increment at count 9999 SHALL NOT wrap. The count SHALL hold at 9999 and the FSM SHALL go to OVF on that edge.
REQ-020 OVF SHALL be exited only by clear or rst. start, stop and lap SHALL be ignored in OVF.
REQ-021 running and ovf SHALL be registered state decodes, valid the cycle after the transitioning edge.
REQ-022 When held=0, bcd SHALL equal the live count (same-cycle, no extra latency).
REQ-023 Hold behaviour SHALL be as defined in REQ-027/REQ-028.

Reset
REQ-024 On rst: state=IDLE, count=0000, prescaler=0, hold register=0000, bcd=16'h0000, running=0, held=0, ovf=0.
REQ-025 rst SHALL override all other inputs, including mid-count and in OVF. No partial increment survives reset.
REQ-026 The block SHALL NOT rely on initial statements for any functional value.

Configuration
REQ-027 With macro BCD_STOPWATCH_LAP_HOLD_EN defined, lap in RUN or PAUSE SHALL toggle held:
- On 0->1, the hold register captures the live count on that edge, and bcd shows the hold register while counting continues underneath.
- On 1->0, bcd returns to the live count.
- Entering OVF SHALL force held=0.
REQ-028 Without BCD_STOPWATCH_LAP_HOLD_EN, lap SHALL be ignored, held SHALL be constant 0, and no hold register SHALL be synthesised.

Verification (PRESCALE=4)
REQ-029 rst, then start pulse -> running=1 the next cycle; bcd=0001 after 4 cycles in RUN; bcd=0010 after 40 cycles; every nibble always <=9.
REQ-030 Count to 0005, stop pulse, wait 20 cycles, start pulse -> bcd stays 0005 while paused; reaches 0006 exactly 4 cycles after re-entering RUN.
REQ-031 Run to 9999 plus one more prescale period -> bcd=9999, ovf=1, running=0; start/stop/lap ignored; clear pulse -> bcd=0000, state IDLE, ovf=0.
REQ-032 stop and clear asserted in the same cycle during RUN at 0123 -> IDLE with bcd=0000 (clear wins). rst asserted mid-prescale at 0042 -> all outputs at reset values next cycle.
REQ-033 (LAP_HOLD_EN) At 0037 in RUN, lap pulse -> held=1 and bcd frozen at 0037 while the live count advances. Second lap at live 0050 -> held=0, bcd=0050. Build without the macro -> lap has no effect and held=0.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control/display bundle for bcd_stopwatch_ctrl: single-cycle requests in,
// packed BCD display and status out.
interface bcd_stopwatch_ctrl_if;
   logic        start;
   logic        stop;
   logic        clear;
   logic        lap;
   logic [15:0] bcd;
   logic        running;
   logic        held;
   logic        ovf;

   modport master (output start, stop, clear, lap, input bcd, running, held, ovf);
   modport slave  (input start, stop, clear, lap, output bcd, running, held, ovf);
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// 4-digit BCD stopwatch: IDLE/RUN/PAUSE/OVF with a PRESCALE-cycle tick.
// Optional display hold (lap) is built only when BCD_STOPWATCH_LAP_HOLD_EN is defined.
module bcd_stopwatch_ctrl #(
   parameter int unsigned PRESCALE = 1000
) (
   input logic                  clk,
   input logic                  rst,
   bcd_stopwatch_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_OVF   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] presc_q, presc_d;
   logic        tick;
   logic        ovf_entry;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = '0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick = (state_q == S_RUN) && (presc_q == 16'(PRESCALE - 1));

   // The increment on a RUN edge happens even if stop arrives on that edge;
   // reaching 9999 overrides stop/start so OVF is never missed.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      presc_d   = presc_q;
      ovf_entry = 1'b0;
      if (bus.clear) begin
         state_d = S_IDLE;
         count_d = '0;
         presc_d = '0;
      end else if (state_q != S_OVF) begin
         if (state_q == S_RUN) begin
            if (tick) begin
               presc_d = '0;
               if (count_q == 16'h9999) begin
                  state_d   = S_OVF;
                  ovf_entry = 1'b1;
               end else begin
                  count_d = bcd_inc(count_q);
               end
            end else begin
               presc_d = presc_q + 16'd1;
            end
         end
         if (!ovf_entry) begin
            if (bus.stop) begin
               if (state_q == S_RUN) state_d = S_PAUSE;
            end else if (bus.start && (state_q == S_IDLE || state_q == S_PAUSE)) begin
               state_d = S_RUN;
               presc_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
      end
   end

   assign bus.running = (state_q == S_RUN);
   assign bus.ovf     = (state_q == S_OVF);

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
   logic        held_q, held_d;
   logic [15:0] hold_q, hold_d;

   always_comb begin
      held_d = held_q;
      hold_d = hold_q;
      if (bus.clear || ovf_entry) begin
         held_d = 1'b0;
      end else if (bus.lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
         held_d = !held_q;
         if (!held_q) hold_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q <= 1'b0;
         hold_q <= '0;
      end else begin
         held_q <= held_d;
         hold_q <= hold_d;
      end
   end

   assign bus.held = held_q;
   assign bus.bcd  = held_q ? hold_q : count_q;
`else
   assign bus.held = 1'b0;
   assign bus.bcd  = count_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (PRESCALE=4): directed scenarios
// with literal expectations, then random requests against an integer-count model.
module tb_bcd_stopwatch_ctrl;

   localparam int P = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   // Reference model: plain integer count and phase, state as flags.
   int m_count, m_phase, m_hold;
   bit m_run, m_pause, m_ovf, m_held;

   bcd_stopwatch_ctrl_if sw ();

   bcd_stopwatch_ctrl #(.PRESCALE(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sw)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_step();
      bit was_run, was_pause;
      int old;
      if (rst) begin
         m_count = 0; m_phase = 0; m_run = 0; m_pause = 0; m_ovf = 0; m_held = 0; m_hold = 0;
         return;
      end
      if (sw.clear) begin
         m_count = 0; m_phase = 0; m_run = 0; m_pause = 0; m_ovf = 0; m_held = 0;
         return;
      end
      if (m_ovf) return;
      was_run   = m_run;
      was_pause = m_pause;
      old       = m_count;
      if (was_run) begin
         m_phase++;
         if (m_phase == P) begin
            m_phase = 0;
            if (m_count == 9999) begin
               m_run = 0; m_ovf = 1; m_held = 0;
               return;
            end
            m_count++;
         end
      end
      if (sw.stop) begin
         if (was_run) begin m_run = 0; m_pause = 1; end
      end else if (sw.start && !was_run) begin
         m_run = 1; m_pause = 0; m_phase = 0;
      end
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
      if (sw.lap && (was_run || was_pause)) begin
         if (!m_held) m_hold = old;
         m_held = !m_held;
      end
`endif
   endtask

   task automatic compare_model();
      logic [15:0] b;
      bit bad;
      b = sw.bcd;
      chk("bcd",     b, m_held ? to_bcd(m_hold) : to_bcd(m_count));
      chk("running", 16'(sw.running), 16'(m_run));
      chk("held",    16'(sw.held),    16'(m_held));
      chk("ovf",     16'(sw.ovf),     16'(m_ovf));
      bad = 1'b0;
      for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      chk("nibble_legal", 16'(bad), 16'd0);
   endtask

   // One clock: model follows the edge, compare on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic wait_edges(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_start(); sw.start = 1'b1; cyc(); sw.start = 1'b0; endtask
   task automatic pulse_stop();  sw.stop  = 1'b1; cyc(); sw.stop  = 1'b0; endtask
   task automatic pulse_clear(); sw.clear = 1'b1; cyc(); sw.clear = 1'b0; endtask
   task automatic pulse_lap();   sw.lap   = 1'b1; cyc(); sw.lap   = 1'b0; endtask

   initial begin
      sw.start = 1'b0; sw.stop = 1'b0; sw.clear = 1'b0; sw.lap = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wait_edges(2);
      rst = 1'b0;
      chk("rst_bcd",     sw.bcd, 16'h0000);
      chk("rst_running", 16'(sw.running), 16'd0);
      chk("rst_ovf",     16'(sw.ovf), 16'd0);
      chk("rst_held",    16'(sw.held), 16'd0);

      // Start, first increment, tens carry
      pulse_start();
      chk("start_running", 16'(sw.running), 16'd1);
      wait_edges(4);
      chk("first_inc", sw.bcd, 16'h0001);
      wait_edges(36);
      chk("forty_cycles", sw.bcd, 16'h0010);

      // Pause/resume
      pulse_clear();
      pulse_start();
      wait_edges(20);
      chk("at_five", sw.bcd, 16'h0005);
      pulse_stop();
      wait_edges(20);
      chk("paused_hold", sw.bcd, 16'h0005);
      chk("paused_running", 16'(sw.running), 16'd0);
      pulse_start();
      wait_edges(3);
      chk("resume_early", sw.bcd, 16'h0005);
      wait_edges(1);
      chk("resume_inc", sw.bcd, 16'h0006);

      // Overflow
      pulse_clear();
      pulse_start();
      wait_edges(9999 * P);
      chk("at_9999", sw.bcd, 16'h9999);
      chk("at_9999_running", 16'(sw.running), 16'd1);
      wait_edges(P);
      chk("ovf_bcd", sw.bcd, 16'h9999);
      chk("ovf_flag", 16'(sw.ovf), 16'd1);
      chk("ovf_running", 16'(sw.running), 16'd0);
      pulse_start();
      pulse_stop();
      pulse_lap();
      wait_edges(6);
      chk("ovf_sticky", 16'(sw.ovf), 16'd1);
      chk("ovf_sticky_bcd", sw.bcd, 16'h9999);
      pulse_clear();
      chk("ovf_clear_bcd", sw.bcd, 16'h0000);
      chk("ovf_clear_flag", 16'(sw.ovf), 16'd0);

      // stop+clear together, then reset mid-prescale
      pulse_start();
      wait_edges(123 * P);
      chk("at_0123", sw.bcd, 16'h0123);
      sw.stop = 1'b1; sw.clear = 1'b1;
      cyc();
      sw.stop = 1'b0; sw.clear = 1'b0;
      chk("clear_wins_bcd", sw.bcd, 16'h0000);
      chk("clear_wins_running", 16'(sw.running), 16'd0);
      pulse_start();
      wait_edges(42 * P + 2);
      chk("at_0042", sw.bcd, 16'h0042);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_bcd", sw.bcd, 16'h0000);
      chk("midrst_running", 16'(sw.running), 16'd0);
      wait_edges(2 * P);
      chk("midrst_idle", sw.bcd, 16'h0000);

      // Lap hold
      pulse_start();
      wait_edges(37 * P);
      chk("at_0037", sw.bcd, 16'h0037);
      pulse_lap();
      wait_edges(50 * P - 37 * P - 1);
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
      chk("lap_frozen", sw.bcd, 16'h0037);
      chk("lap_held", 16'(sw.held), 16'd1);
`else
      chk("lap_ignored", sw.bcd, 16'h0050);
      chk("lap_held0", 16'(sw.held), 16'd0);
`endif
      pulse_lap();
      chk("lap_release", sw.bcd, 16'h0050);
      chk("lap_release_held", 16'(sw.held), 16'd0);

      // Random requests
      for (int i = 0; i < 4000; i++) begin
         sw.start = ($urandom_range(0, 7) == 0);
         sw.stop  = ($urandom_range(0, 15) == 0);
         sw.clear = ($urandom_range(0, 79) == 0);
         sw.lap   = ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 599) == 0);
         cyc();
      end
      sw.start = 1'b0; sw.stop = 1'b0; sw.clear = 1'b0; sw.lap = 1'b0; rst = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
